// File: rtl/clock_ctrl_pkg.sv
// ============================================================================
// clock_ctrl_pkg
// Shared state encoding and default widths for the clock run controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clock_ctrl_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PERF_W = 32;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/clock_run_ctrl_sat_counter.sv
// ============================================================================
// sat_counter
// Up-counter that holds at all-ones instead of wrapping; cleared by reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/clock_run_ctrl.sv
// ============================================================================
// clock_run_ctrl
// Run / halt / single-step arbiter producing the clock generator enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_run_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STARTUP_DLY = 4,
  parameter int PERF_W      = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              step_req,
  input  logic [CNT_W-1:0]  step_count,
  input  logic              halt_req,
  input  logic              cpu_halt,
  output logic              clk_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] cycle_count
);

  localparam int                 c_dly_w    = $clog2(STARTUP_DLY + 1);
  localparam logic [c_dly_w-1:0] c_dly_init = c_dly_w'(STARTUP_DLY);

  state_t             r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
  logic [c_dly_w-1:0] r_startup,   w_startup_nxt;
  logic               r_done,      w_done_nxt;
  logic               w_abort;

  assign w_abort = halt_req | cpu_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT;
      r_remaining <= '0;
      r_startup   <= c_dly_init;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_startup   <= w_startup_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_startup_nxt   = r_startup;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_startup_nxt = r_startup - c_dly_w'(1);
        if (r_startup == c_dly_w'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A run request blocked by cpu_halt still wins priority over step.
        if (halt_req) begin
          w_state_nxt = ST_IDLE;
        end else if (run_req) begin
          if (!cpu_halt) begin
            w_state_nxt = ST_RUN;
          end
        end else if (step_req) begin
          if (step_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_STEP;
            w_remaining_nxt = step_count;
          end
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_STEP: begin
        if (w_abort || (r_remaining == CNT_W'(1))) begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = '0;
          w_done_nxt      = 1'b1;
        end else begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase
  end

  assign clk_en = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign state  = r_state;

  sat_counter #(
    .WIDTH (PERF_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (clk_en),
    .count (cycle_count)
  );

endmodule

`default_nettype wire

// File: doc/clock_run_ctrl.md
Name: clock_run_ctrl

Overview:
Run/halt/single-step controller for the processor clock generator.
- Produces the `enable` that gates the 50% duty clock.
- Arbitrates between debug/testbench requests (`run`, `step`, `halt`) and the core's own halt signal.
- Sits between the top-level testbench/debug interface and the clock generator instance.
- Counts enabled cycles for performance reporting.

Parameters:
- CNT_W, 16, width of `step_count` and the internal remaining-steps counter.
- STARTUP_DLY, 4, cycles after reset deassertion before requests are accepted (must be ≥1).
- PERF_W, 32, width of `cycle_count`.

Ports:
- clk  input  1  free-running reference clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- run_req  input  1  level/pulse; start free run.
- step_req  input  1  pulse; start a step burst of `step_count` cycles.
- step_count  input  CNT_W  burst length, sampled when `step_req` is accepted.
- halt_req  input  1  debug halt; aborts RUN or STEP.
- cpu_halt  input  1  core executed halt; stops RUN/STEP.
- clk_en  output  1  enable to the clock generator.
- busy  output  1  high when state ≠ IDLE.
- done  output  1  one-cycle pulse when RUN/STEP ends.
- state  output  2  current state encoding (debug visibility).
- cycle_count  output  PERF_W  number of cycles with `clk_en`=1.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=WAIT; clk_en=0, busy=1, done=0, cycle_count=0.
  - remaining=0; startup counter loaded with STARTUP_DLY.
- States: WAIT=0, IDLE=1, RUN=2, STEP=3. `clk_en` = (state==RUN || state==STEP), decoded directly from the state register.
- WAIT:
  - Startup counter decrements each cycle; on reaching 0 → IDLE.
  - All requests are ignored, not queued.
- IDLE (requests sampled at posedge; effect visible the following cycle):
  - Priority order: `halt_req` > `run_req` > `step_req`.
  - `halt_req`=1 → stay IDLE, no done.
  - `run_req`=1 and `cpu_halt`=0 → RUN.
  - `run_req`=1 and `cpu_halt`=1 → ignored, stay IDLE.
  - `step_req`=1, `step_count`≠0 → STEP, remaining=step_count. Allowed even if `cpu_halt`=1, so the core can be stepped past a halt.
  - `step_req`=1, `step_count`=0 → stay IDLE, done pulses next cycle.
- RUN:
  - `halt_req` or `cpu_halt` high at a posedge → IDLE; `clk_en` low from next cycle; done=1 for that one cycle.
  - `run_req`/`step_req` while in RUN are ignored.
- STEP:
  - `clk_en` high for exactly the sampled `step_count` cycles.
  - remaining decrements each STEP cycle; when remaining==1 at a posedge → IDLE, remaining=0, done pulses.
  - `halt_req` or `cpu_halt` → immediate IDLE, remaining cleared, done pulses. Fewer than N cycles are then delivered.
  - Other requests are ignored.
- cycle_count:
  - Increments on each posedge where `clk_en`=1.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- done: registered, one cycle wide; never asserted in WAIT.
- Reset mid-RUN/STEP: outputs go to reset values immediately (asynchronously); no done pulse.
- Simultaneous halt and completion in STEP: a single done pulse.

Decomposition:
- Package `clock_ctrl_pkg`:
  - state enum (WAIT/IDLE/RUN/STEP, 2-bit encodings as above).
  - default CNT_W/PERF_W localparams.
- One sub-module, `sat_counter` (parameterized width, inc, clear-on-reset, saturate), used for `cycle_count`.
- The step down-counter stays inline.

Test Plan:
1. Reset → release; `run_req` at cycle 1 → ignored. After 4 cycles state=IDLE, busy=0, clk_en=0, cycle_count=0.
2. IDLE: `step_req`, `step_count`=5 → clk_en high exactly 5 cycles, then done pulse 1 cycle, cycle_count=5, state=IDLE.
3. `run_req` → RUN; after 10 enabled cycles assert `cpu_halt` → clk_en low next cycle, done=1 once, cycle_count=10. `run_req` while `cpu_halt` held → stays IDLE.
4. STEP `step_count`=100, `halt_req` after 7 enabled cycles → clk_en drops, done pulse, cycle_count=+7; a subsequent STEP 1 gives exactly 1 cycle.
5. `step_req` with `step_count`=0 → no clk_en, done pulse next cycle. `run_req`+`step_req` same cycle → RUN chosen. `halt_req`+`run_req` in IDLE → stays IDLE.
6. Reset asserted mid-RUN → clk_en=0 asynchronously, cycle_count=0, state=WAIT, no done. PERF_W=4, run 20 cycles → cycle_count saturates at 15.
